// File: rtl/ivector_pkg.sv
// Shared constants for the IVector heard() serializer: FSM encodings, header layout, defaults.
package ivector_pkg;

  localparam int          HALF_WIDTH_DEF = 192;
  localparam int          WORD_WIDTH_DEF = 32;
  localparam logic [15:0] METHOD_ID_DEF  = 16'h0001;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam int HDR_SEQ_LSB = 0;
  localparam int HDR_LEN_LSB = 8;
  localparam int HDR_ID_LSB  = 16;

  function automatic int nwords(input int half_width, input int word_width);
    return (2 * half_width) / word_width;
  endfunction

  function automatic logic [31:0] make_hdr(input logic [15:0] id, input logic [7:0] len,
                                           input logic [7:0] seq);
    logic [31:0] h;
    h = '0;
    h[HDR_ID_LSB  +: 16] = id;
    h[HDR_LEN_LSB +: 8]  = len;
    h[HDR_SEQ_LSB +: 8]  = seq;
    return h;
  endfunction

endpackage

// File: rtl/ivector_word_mux.sv
// Selects word sel_i (LS word = 0) from a wide vector.
// Latency: combinational. Backpressure: none, pure datapath.
module ivector_word_mux #(
  parameter int VEC_WIDTH  = 384,
  parameter int WORD_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic [VEC_WIDTH-1:0]  vec_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  output logic [WORD_WIDTH-1:0] word_o
);

  localparam int NW = VEC_WIDTH / WORD_WIDTH;

  always_comb begin
    word_o = '0;
    for (int k = 0; k < NW; k++) begin
      if (sel_i == SEL_WIDTH'(k)) word_o = vec_i[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

endmodule

// File: rtl/ivector_heard_serializer.sv
// Serializes heard(meth, v) into a header + NWORDS payload frame; header valid the cycle after accept.
// Output stalls hold word/state; IVECTOR_SER_SKID_EN adds a holding buffer so a frame can queue with no bubble.
module ivector_heard_serializer
  import ivector_pkg::*;
#(
  parameter int          HALF_WIDTH = HALF_WIDTH_DEF,
  parameter int          WORD_WIDTH = WORD_WIDTH_DEF,
  parameter logic [15:0] METHOD_ID  = METHOD_ID_DEF
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  heard__ENA,
  input  logic [HALF_WIDTH-1:0] heard_meth,
  input  logic [HALF_WIDTH-1:0] heard_v,
  output logic                  heard__RDY,
  output logic                  out__ENA,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out__RDY
);

  localparam int              NWORDS   = nwords(HALF_WIDTH, WORD_WIDTH);
  localparam int              CW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int              VW       = 2 * HALF_WIDTH;
  localparam logic [CW-1:0]   CNT_LAST = CW'(NWORDS - 1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            seq_q, seq_d;
  logic [VW-1:0]         buf_q, buf_d;
  logic                  busy, last_word, xfer, last_xfer, accept;
  logic [WORD_WIDTH-1:0] pay_word, hdr_word;

  ivector_word_mux #(
    .VEC_WIDTH (VW),
    .WORD_WIDTH(WORD_WIDTH),
    .SEL_WIDTH (CW)
  ) u_word_mux (
    .vec_i (buf_q),
    .sel_i (cnt_q),
    .word_o(pay_word)
  );

  assign hdr_word  = WORD_WIDTH'(make_hdr(METHOD_ID, 8'(NWORDS), seq_q));
  assign busy      = (state_q == HDR) || (state_q == DATA);
  assign last_word = (state_q == DATA) && (cnt_q == CNT_LAST);
  assign xfer      = out__ENA & out__RDY;
  assign last_xfer = xfer & last_word;
  assign accept    = heard__ENA & heard__RDY;

  // Outputs are gated by nRST so nothing is offered while reset is held.
  assign out__ENA = nRST & busy;
  assign out_last = nRST & last_word;
  always_comb begin
    out_data = '0;
    if (nRST && state_q == HDR)  out_data = hdr_word;
    if (nRST && state_q == DATA) out_data = pay_word;
  end

`ifdef IVECTOR_SER_SKID_EN
  logic [VW-1:0] hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;

  assign heard__RDY = nRST & ~hold_vld_q;
`else
  assign heard__RDY = nRST & (state_q == IDLE);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (accept) begin
        buf_d   = {heard_v, heard_meth};
        state_d = HDR;
      end
      HDR: if (xfer) begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: if (last_xfer) begin
        cnt_d   = '0;
        seq_d   = seq_q + 8'd1;
        state_d = IDLE;
      end else if (xfer) begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef IVECTOR_SER_SKID_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (busy && accept && !last_xfer) begin
      hold_d     = {heard_v, heard_meth};
      hold_vld_d = 1'b1;
    end
    // End of frame chains the next one straight into HDR: queued first, else a same-cycle arrival.
    if (last_xfer) begin
      if (hold_vld_q) begin
        buf_d      = hold_q;
        hold_vld_d = 1'b0;
        state_d    = HDR;
      end else if (accept) begin
        buf_d   = {heard_v, heard_meth};
        state_d = HDR;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
    end
    buf_q <= buf_d;
  end

`ifdef IVECTOR_SER_SKID_EN
  always_ff @(posedge CLK) begin
    if (!nRST) hold_vld_q <= 1'b0;
    else       hold_vld_q <= hold_vld_d;
    hold_q <= hold_d;
  end
`endif

endmodule

// File: tb/tb_ivector_heard_serializer.sv
// Directed bench for ivector_heard_serializer: reset, framing, stalls, seq wrap, mid-frame reset, skid.
module tb_ivector_heard_serializer;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         heard__ENA = 1'b0;
  logic [191:0] heard_meth = '0;
  logic [191:0] heard_v = '0;
  logic         heard__RDY;
  logic         out__ENA;
  logic [31:0]  out_data;
  logic         out_last;
  logic         out__RDY = 1'b0;

  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   seq = 8'd0;
  logic [383:0] vec_a, vec_b;
  logic [15:0]  pat = 16'b1001_1001_0011_1001;

  always #5 CLK = ~CLK;

  ivector_heard_serializer dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .heard__ENA(heard__ENA),
    .heard_meth(heard_meth),
    .heard_v   (heard_v),
    .heard__RDY(heard__RDY),
    .out__ENA  (out__ENA),
    .out_data  (out_data),
    .out_last  (out_last),
    .out__RDY  (out__RDY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Called at a negedge where the frame's header should already be visible.
  task automatic recv_frame(input logic [383:0] vec, input logic [7:0] s, input bit stall,
                            input int abort_at, input bit inject);
    int          idx = 0;
    int          cyc = 0;
    logic        rdy;
    logic [31:0] exp;
    while (idx < abort_at && cyc < 200) begin
      if (out__ENA) begin
        exp = (idx == 0) ? {16'h0001, 8'd12, s} : vec[(idx-1)*32 +: 32];
        chk("word", out_data, exp);
        chk("last", {31'd0, out_last}, {31'd0, idx == 12});
      end else begin
        chk("ena", {31'd0, out__ENA}, 32'd1);
      end
      if (inject && cyc == 4) begin
        chk("skid_rdy", {31'd0, heard__RDY}, 32'd1);
        heard__ENA = 1'b1;
        heard_meth = vec_b[191:0];
        heard_v    = vec_b[383:192];
      end
      if (inject && cyc == 5) heard__ENA = 1'b0;
      if (inject && cyc == 8) chk("third_rdy", {31'd0, heard__RDY}, 32'd0);
      rdy = stall ? pat[cyc[3:0]] : 1'b1;
      out__RDY = rdy;
      if (rdy && out__ENA) idx++;
      cyc++;
      if (idx < abort_at) @(negedge CLK);
    end
    if (idx < abort_at) chk("timeout", idx, abort_at);
  endtask

  task automatic send_frame(input logic [383:0] vec, input bit stall, input int abort_at,
                            input bit inject);
    @(negedge CLK);
    chk("acc_rdy", {31'd0, heard__RDY}, 32'd1);
    heard__ENA = 1'b1;
    heard_meth = vec[191:0];
    heard_v    = vec[383:192];
    @(negedge CLK);
    heard__ENA = 1'b0;
    recv_frame(vec, seq, stall, abort_at, inject);
    if (abort_at == 13) seq = seq + 8'd1;
  endtask

  initial begin
    for (int k = 0; k < 12; k++) begin
      vec_a[k*32 +: 32] = 32'h1000_0000 + k;
      vec_b[k*32 +: 32] = 32'h2000_0000 + k;
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_rdy", {31'd0, heard__RDY}, 32'd0);
      chk("rst_ena", {31'd0, out__ENA}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
    end
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_rst_rdy", {31'd0, heard__RDY}, 32'd1);

    send_frame(vec_a, 1'b0, 13, 1'b0);
    @(negedge CLK);
    chk("bubble_ena", {31'd0, out__ENA}, 32'd0);
    chk("bubble_rdy", {31'd0, heard__RDY}, 32'd1);

    send_frame(vec_a, 1'b1, 13, 1'b0);

    send_frame(vec_b, 1'b0, 6, 1'b0);
    @(negedge CLK);
    nRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("abort_ena", {31'd0, out__ENA}, 32'd0);
      chk("abort_rdy", {31'd0, heard__RDY}, 32'd0);
    end
    nRST = 1'b1;
    seq  = 8'd0;
    @(negedge CLK);
    chk("abort_idle_ena", {31'd0, out__ENA}, 32'd0);

    for (int f = 0; f < 257; f++) send_frame((f % 2 == 0) ? vec_a : vec_b, 1'b0, 13, 1'b0);
    chk("seq_wrapped", {24'd0, seq}, 32'd1);

`ifdef IVECTOR_SER_SKID_EN
    send_frame(vec_a, 1'b0, 13, 1'b1);
    @(negedge CLK);
    recv_frame(vec_b, seq, 1'b0, 13, 1'b0);
    seq = seq + 8'd1;
`endif
    @(negedge CLK);
    chk("end_ena", {31'd0, out__ENA}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
